instruction_loader: RTL and testbench
=====================================

# instruction_loader

Write-side companion to the processor's byte-addressed instruction memory. Accepts 32-bit instruction words over a valid/ready stream and writes each one into the 256-byte program store as four consecutive big-endian byte writes. The fetch side assembles bytes `pc..pc+3` MSB-first, so words loaded here read back unchanged. The block sits between a host/boot source and the memory's byte write port. It holds the core in `busy` while a program image is being loaded.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: byte address width; memory depth is 2^ADDR_WIDTH bytes.
- `CNT_WIDTH`, default ADDR_WIDTH-1: width of the word count; covers 0..2^(ADDR_WIDTH-2) words.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `start`, input, 1: one-cycle load request; honoured only in IDLE.
- `base_addr`, input, ADDR_WIDTH: first byte address; bits [1:0] are forced to 0.
- `word_count`, input, CNT_WIDTH: number of words to load; sampled with `start`.
- `in_valid`, input, 1: `in_word` holds a valid instruction.
- `in_word`, input, 32: instruction word.
- `in_ready`, output, 1: loader accepts `in_word` this cycle.
- `mem_we`, output, 1: byte write strobe.
- `mem_addr`, output, ADDR_WIDTH: byte write address.
- `mem_wdata`, output, 8: byte write data.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse when the last byte has been written.
- `words_written`, output, CNT_WIDTH: words fully written in the current or most recent load.

## Operation
- States:
  - IDLE: on `start`, latch the address pointer as {base_addr[ADDR_WIDTH-1:2],2'b00} and latch the remaining count. Clear `words_written`. Go to ACCEPT, or to DONE if `word_count`==0.
  - ACCEPT: `in_ready`=1. On a handshake (`in_valid & in_ready`), latch the word, set lane=0, go to WRITE.
  - WRITE: `mem_we`=1 and `mem_wdata`=word[31-8*lane -: 8] at `mem_addr`=pointer. After each byte, pointer increments by 1 and lane increments by 1.
    - On lane 3, `words_written` increments and remaining decrements.
    - If remaining becomes 0, go to DONE.
    - Otherwise `in_ready`=1 during lane 3. A handshake on that cycle loads the next word and restarts lane 0 with no gap. With no handshake, go to ACCEPT.
  - DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- `in_ready` is asserted only in ACCEPT, or in WRITE lane 3 when remaining > 1.
- `start` outside IDLE is ignored.
- The pointer wraps modulo 2^ADDR_WIDTH; a load that crosses 0xFF continues at 0x00.
- `word_count` greater than the memory size simply overwrites earlier bytes; no error is flagged.
- The `in_valid` source may stall indefinitely in ACCEPT. `busy` stays high throughout.
- `mem_wdata` and `mem_addr` are don't-care when `mem_we`=0, but are held at their last value (no toggling).

## Timing
- All outputs are registered. Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `words_written`=0, state=IDLE.
- `start` in cycle N gives `busy`=1 and `in_ready`=1 in cycle N+1.
- A handshake in cycle H puts byte 0 on the write port in H+1, then bytes 1..3 in H+2..H+4.
- Sustained throughput is 1 word per 4 cycles when `in_valid` is held high.
- `done` is asserted in the cycle after the last byte write, with `busy`=0 in the same cycle. The block can take a new `start` in the cycle after `done`.
- `word_count`=0: `done` in N+2 and no `mem_we`.
- Reset mid-load: all outputs return to reset values immediately (asynchronously). Bytes already written remain in memory. No partial-word recovery is attempted.

## Structure
- Shared package holds:
  - the state encoding (IDLE, ACCEPT, WRITE, DONE);
  - the lane constants (LANE_MSB=0 … LANE_LSB=3);
  - the big-endian byte-select convention used by both the loader and the fetch path.
- One sub-module is natural: `word_serializer`, the 32-to-8 lane shifter plus lane counter. The top-level instance holds the FSM, pointer, and counters.

## Test plan
- Single word: base 0x00, count 1, word 0x8C010004. Required writes: 0x00=8C, 0x01=01, 0x02=00, 0x03=04 on four consecutive cycles. Then `done` pulse, `words_written`=1.
- Back-to-back: count 2, `in_valid` held high, words 0x20020005 and 0x00430820. Required: 8 consecutive `mem_we` cycles with no gap, at addresses 0x10..0x17 from base 0x12 (low bits forced to 0).
- Wrap: base 0xFC, count 2. Required writes at 0xFC..0xFF, then 0x00..0x03. `done` after the 8th byte.
- Stall and ignore: `in_valid` low for 5 cycles in ACCEPT gives no `mem_we` and `busy`=1. A `start` pulse while busy is ignored (count unchanged). `word_count`=0 gives a `done` pulse with zero writes.
- Reset mid-word: assert `reset` after 2 bytes of a word. Required: all outputs 0 immediately. A subsequent load at base 0x40, count 1 completes normally.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the fetch path:
// FSM encoding, byte-lane numbering and the big-endian byte-select rule.
package instruction_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [LANE_W-1:0] LANE_MSB = 2'd0;
  localparam logic [LANE_W-1:0] LANE_B1  = 2'd1;
  localparam logic [LANE_W-1:0] LANE_B2  = 2'd2;
  localparam logic [LANE_W-1:0] LANE_LSB = 2'd3;

  // Byte at address offset `lane` within a word; offset 0 is the MSB.
  function automatic logic [BYTE_W-1:0] be_byte(input logic [WORD_W-1:0] word,
                                                input logic [LANE_W-1:0] lane);
    logic [BYTE_W-1:0] b;
    case (lane)
      LANE_MSB: b = word[31:24];
      LANE_B1:  b = word[23:16];
      LANE_B2:  b = word[15:8];
      default:  b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/instruction_loader_word_serializer.sv
// 32-to-8 lane shifter: holds the current word and presents one registered
// big-endian byte per lane, advancing on request.
module word_serializer
  import instruction_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                advance_i,
  input  logic [WORD_W-1:0]   word_i,
  output logic [LANE_W-1:0]   lane_o,
  output logic [BYTE_W-1:0]   byte_o
);

  logic [WORD_W-1:0] word_q;
  logic [LANE_W-1:0] lane_q;
  logic [BYTE_W-1:0] byte_q;
  logic [LANE_W-1:0] lane_d;

  assign lane_d = lane_q + LANE_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      lane_q <= LANE_MSB;
      byte_q <= '0;
    end else if (load_i) begin
      word_q <= word_i;
      lane_q <= LANE_MSB;
      byte_q <= be_byte(word_i, LANE_MSB);
    end else if (advance_i) begin
      lane_q <= lane_d;
      byte_q <= be_byte(word_q, lane_d);
    end
  end

  assign lane_o = lane_q;
  assign byte_o = byte_q;

endmodule

// File: rtl/instruction_loader.sv
// Streams 32-bit instruction words into the byte-wide program store as four
// big-endian byte writes each, holding the core in busy for the whole load.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = ADDR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  in_valid,
  input  logic [WORD_W-1:0]     in_word,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BYTE_W-1:0]     mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  words_written
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [CNT_WIDTH-1:0]  words_written_q;
  logic                  in_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  busy_q;
  logic                  done_q;
  logic [LANE_W-1:0]     lane;
  logic                  handshake;
  logic                  advance;

  assign handshake = in_valid & in_ready_q;
  assign advance   = (state_q == ST_WRITE) && (lane != LANE_LSB);
  assign ptr_d     = ptr_q + ADDR_WIDTH'(1);

  word_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .load_i    (handshake),
    .advance_i (advance),
    .word_i    (in_word),
    .lane_o    (lane),
    .byte_o    (mem_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      remaining_q     <= '0;
      words_written_q <= '0;
      in_ready_q      <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            ptr_q           <= base_addr & ~ADDR_WIDTH'(3);
            remaining_q     <= word_count;
            words_written_q <= '0;
            busy_q          <= 1'b1;
            if (word_count == '0) begin
              state_q <= ST_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ST_ACCEPT;
            end
          end
        end
        ST_ACCEPT: begin
          if (handshake) begin
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b1;
            mem_addr_q <= ptr_q;
            ptr_q      <= ptr_d;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (lane != LANE_LSB) begin
            mem_addr_q <= ptr_q;
            ptr_q      <= ptr_d;
            // Open the input one cycle early so the next word follows gaplessly.
            if (lane == LANE_B2 && remaining_q > CNT_WIDTH'(1)) begin
              in_ready_q <= 1'b1;
            end
          end else begin
            words_written_q <= words_written_q + CNT_WIDTH'(1);
            remaining_q     <= remaining_q - CNT_WIDTH'(1);
            if (remaining_q == CNT_WIDTH'(1)) begin
              mem_we_q   <= 1'b0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= ST_DONE;
            end else if (handshake) begin
              in_ready_q <= 1'b0;
              mem_addr_q <= ptr_q;
              ptr_q      <= ptr_d;
            end else begin
              mem_we_q   <= 1'b0;
              in_ready_q <= 1'b1;
              state_q    <= ST_ACCEPT;
            end
          end
        end
        ST_DONE: begin
          // A zero-word load arrives here still busy and emits done one cycle later.
          if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected byte writes are queued
// as words are handed over and compared as the write port produces them.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic [6:0]  words_written;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_cnt   = 0;
  int   run_len  = 0;
  int   max_run  = 0;
  logic [7:0] exp_ptr;

  instruction_loader dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .in_valid      (in_valid),
    .in_word       (in_word),
    .in_ready      (in_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Write-port monitor: pops the scoreboard and tracks back-to-back run length.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wr_cnt++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    wr_t e;
    for (int b = 0; b < 4; b++) begin
      e.addr = exp_ptr;
      e.data = w[31-8*b -: 8];
      exp_q.push_back(e);
      exp_ptr = exp_ptr + 8'd1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] base, input int cnt);
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = 7'(cnt);
    exp_ptr    = base & 8'hFC;
    wr_cnt     = 0;
    max_run    = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  // Hand one word over once in_ready is seen; leaves in_valid high.
  task automatic give_word(input logic [31:0] w);
    int guard;
    logic [7:0] a0;
    in_valid = 1'b1;
    in_word  = w;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      a0 = exp_ptr;
      push_word(w);
      @(posedge clk); #1;
      @(negedge clk);
      check("byte0_we", 32'(mem_we), 32'd1);
      check("byte0_addr", 32'(mem_addr), 32'(a0));
    end
  endtask

  task automatic wait_done(input int cnt);
    int guard;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("words_written", 32'(words_written), 32'(cnt));
    check("write_count", 32'(wr_cnt), 32'(4 * cnt));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic load(input logic [7:0] base, input int cnt,
                      input logic [31:0] w0, input logic [31:0] w1, input int stall);
    pulse_start(base, cnt);
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        start = 1'b1;
        word_count = 7'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      check("stall_we", 32'(mem_we), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    start = 1'b0;
    give_word(w0);
    if (cnt > 1) give_word(w1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_word = '0; exp_ptr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ww", 32'(words_written), 32'd0);
    reset = 1'b0;

    // Single word at base 0.
    load(8'h00, 1, 32'h8C01_0004, 32'h0, 0);
    check("single_run", 32'(max_run), 32'd4);

    // Back-to-back words, base low bits forced to zero.
    load(8'h12, 2, 32'h2002_0005, 32'h0043_0820, 0);
    check("b2b_run", 32'(max_run), 32'd8);

    // Address wrap across 0xFF.
    load(8'hFC, 2, 32'hDEAD_BEEF, 32'h0123_4567, 0);

    // Stall in ACCEPT with an ignored start while busy.
    load(8'h20, 1, 32'hA5A5_5A5A, 32'h0, 5);

    // Zero-word load: done two cycles after start, no writes.
    pulse_start(8'h30, 0);
    check("zero_busy", 32'(busy), 32'd1);
    check("zero_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("zero_writes", 32'(wr_cnt), 32'd0);

    // Reset after two bytes of a word.
    pulse_start(8'h80, 1);
    give_word(32'hCAFE_F00D);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ww", 32'(words_written), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    load(8'h40, 1, 32'h1234_ABCD, 32'h0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
